// File: rtl/hmmm_alu_if.sv
// Control/status bundle between the Hmmm control unit and the ALU.
// The shared data bus itself stays a plain inout on the ALU.
interface hmmm_alu_if;
  logic       a_in;
  logic       b_in;
  logic [2:0] op;
  logic       start;
  logic       alu_out;
  logic       busy;
  logic       done;
  logic       zero;
  logic       negative;
  logic       div_by_zero;

  modport master (
    output a_in, b_in, op, start, alu_out,
    input  busy, done, zero, negative, div_by_zero
  );

  modport slave (
    input  a_in, b_in, op, start, alu_out,
    output busy, done, zero, negative, div_by_zero
  );
endinterface

// File: rtl/hmmm_alu.sv
// Hmmm datapath ALU: single-cycle ADD/SUB/NEG and 16-step iterative
// MUL/DIV/MOD on sign-magnitude operands, result driven onto the shared bus.
module hmmm_alu (
  input  logic        clk,
  input  logic        rst,
  inout  wire  [15:0] data,
  hmmm_alu_if.slave   ctl
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIN = 2'd2} state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MOD = 3'b100;
  localparam logic [2:0] OP_NEG = 3'b101;

  state_t      state_r;
  logic [15:0] a_r, b_r, result_r;
  logic [15:0] ma_r, mb_r, acc_r;
  logic [16:0] rem_r;
  logic [4:0]  cnt_r;
  logic [2:0]  op_r;
  logic        sa_r, sb_r;

  logic [16:0] shift_s, diff_s;
  logic [15:0] single_s, fin_s;
  logic        iter_s, b_zero_s;

  function automatic logic [15:0] neg16(input logic [15:0] v);
    return 16'd0 - v;
  endfunction

  function automatic logic [15:0] abs16(input logic [15:0] v);
    return v[15] ? neg16(v) : v;
  endfunction

  assign data = ctl.alu_out ? result_r : 16'bz;

  // Restoring-division step and single-cycle / final result selection
  always_comb begin
    shift_s  = {rem_r[15:0], ma_r[15]};
    diff_s   = shift_s - {1'b0, mb_r};
    b_zero_s = (mb_r == 16'd0);
    iter_s   = (ctl.op == OP_MUL) || (ctl.op == OP_DIV) || (ctl.op == OP_MOD);
    case (ctl.op)
      OP_ADD:  single_s = a_r + b_r;
      OP_SUB:  single_s = a_r - b_r;
      OP_NEG:  single_s = neg16(a_r);
      default: single_s = a_r;
    endcase
    case (op_r)
      OP_MUL:  fin_s = (sa_r ^ sb_r) ? neg16(acc_r) : acc_r;
      OP_DIV:  fin_s = b_zero_s ? 16'd0 : ((sa_r ^ sb_r) ? neg16(ma_r) : ma_r);
      OP_MOD:  fin_s = b_zero_s ? 16'd0 : (sa_r ? neg16(rem_r[15:0]) : rem_r[15:0]);
      default: fin_s = 16'd0;
    endcase
  end

  // Operand capture, sequencing FSM and registered status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= IDLE;
      a_r             <= 16'd0;
      b_r             <= 16'd0;
      result_r        <= 16'd0;
      ma_r            <= 16'd0;
      mb_r            <= 16'd0;
      acc_r           <= 16'd0;
      rem_r           <= 17'd0;
      cnt_r           <= 5'd0;
      op_r            <= 3'd0;
      sa_r            <= 1'b0;
      sb_r            <= 1'b0;
      ctl.busy        <= 1'b0;
      ctl.done        <= 1'b0;
      ctl.zero        <= 1'b1;
      ctl.negative    <= 1'b0;
      ctl.div_by_zero <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          ctl.done <= 1'b0;
          if (ctl.a_in) a_r <= data;
          if (ctl.b_in) b_r <= data;
          if (ctl.start && iter_s) begin
            op_r     <= ctl.op;
            ma_r     <= abs16(a_r);
            mb_r     <= abs16(b_r);
            sa_r     <= a_r[15];
            sb_r     <= b_r[15];
            acc_r    <= 16'd0;
            rem_r    <= 17'd0;
            cnt_r    <= 5'd0;
            ctl.busy <= 1'b1;
            state_r  <= CALC;
          end else if (ctl.start) begin
            result_r        <= single_s;
            ctl.zero        <= (single_s == 16'd0);
            ctl.negative    <= single_s[15];
            ctl.div_by_zero <= 1'b0;
            ctl.done        <= 1'b1;
          end
        end
        CALC: begin
          if (op_r == OP_MUL) begin
            if (mb_r[0]) acc_r <= acc_r + ma_r;
            ma_r <= {ma_r[14:0], 1'b0};
            mb_r <= {1'b0, mb_r[15:1]};
          end else begin
            // quotient bits shift into ma_r as the dividend bits shift out
            if (!diff_s[16]) begin
              rem_r <= diff_s;
              ma_r  <= {ma_r[14:0], 1'b1};
            end else begin
              rem_r <= shift_s;
              ma_r  <= {ma_r[14:0], 1'b0};
            end
          end
          cnt_r <= cnt_r + 5'd1;
          if (cnt_r == 5'd15) state_r <= FIN;
        end
        FIN: begin
          result_r        <= fin_s;
          ctl.zero        <= (fin_s == 16'd0);
          ctl.negative    <= fin_s[15];
          ctl.div_by_zero <= (op_r != OP_MUL) && b_zero_s;
          ctl.busy        <= 1'b0;
          ctl.done        <= 1'b1;
          state_r         <= IDLE;
        end
        default: begin
          state_r  <= IDLE;
          ctl.busy <= 1'b0;
          ctl.done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/hmmm_alu.md
Name: hmmm_alu

Overview:
- Arithmetic unit for the Hmmm datapath. It sits directly downstream of the register file on the shared 16-bit tristate data bus.
- Captures two signed operands from the bus under control-unit strobes and executes ADD, SUB, NEG, MUL, DIV or MOD.
- Drives the result back onto the bus so the register file can write it.
- MUL, DIV and MOD are iterative (multi-cycle). The rest complete in one cycle.

Parameters:
- none (width fixed at 16, matching the register file)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- data  inout  16  shared data bus, two's complement
- a_in  input  1  capture data into operand A at clock edge
- b_in  input  1  capture data into operand B at clock edge
- op  input  3  operation: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 MOD, 101 NEG, 11x reserved
- start  input  1  begin operation op on captured A and B
- alu_out  input  1  drive result register onto data, else high-Z
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse when result register updated
- zero  output  1  result == 0
- negative  output  1  result[15]
- div_by_zero  output  1  last DIV/MOD had B == 0

Behaviour:
- Reset is synchronous, checked at the clock edge, and overrides everything including an in-flight operation:
  - A, B, result = 0; state IDLE.
  - busy=0, done=0, zero=1, negative=0, div_by_zero=0.
- Bus drive: data = alu_out ? result : Z. Combinational, independent of state, so it may drive a stale result while busy. Bus arbitration belongs to the control unit.
- Operand capture: a_in/b_in load A/B from data at the edge, only in IDLE. They are ignored while busy. a_in and b_in together load the same value into both.
- FSM states are IDLE, CALC, FIN.
- IDLE, start=1 at edge k, single-cycle op (ADD, SUB, NEG, reserved):
  - result written at edge k; done=1 for the following cycle; stays in IDLE.
  - ADD: A+B mod 2^16. SUB: A-B mod 2^16. NEG: 0-A mod 2^16. Reserved ops: result=A.
- IDLE, start=1 at edge k, iterative op (MUL, DIV, MOD):
  - Edge k: latch op; load |A| and |B| as 16-bit unsigned (|-32768| = 0x8000); record sign bits; clear a 5-bit counter; busy=1; go to CALC.
  - CALC: one step per edge, k+1 .. k+16.
    - MUL: shift-add, 16-bit product accumulator. Only the low 16 bits are kept; the sign-fixed result equals (A*B) mod 2^16.
    - DIV/MOD: restoring division with a 17-bit partial remainder, one quotient bit per step, MSB first.
    - Counter reaches 15 at edge k+16 -> go to FIN.
  - FIN, edge k+17:
    - Apply sign and write result; busy=0; done=1 for the following cycle; go to IDLE.
    - Total latency is 17 edges from the start edge to the result.
- Sign rules:
  - MUL: negate if signs differ.
  - DIV: truncate toward zero; negate quotient if signs differ.
  - MOD: remainder takes the sign of A, so A = B*q + r.
- Divide by zero (B == 0, DIV or MOD): still 17 cycles; result=0; div_by_zero=1. Any other completed op clears div_by_zero.
- Overflow: -32768 / -1 = -32768, and MOD gives 0. No overflow flag.
- zero and negative update only when result is written.
- start while busy is ignored: no restart, no queueing. start together with a_in/b_in in IDLE uses the old A/B, since capture and start happen at the same edge.
- done never asserts for more than one cycle. Back-to-back single-cycle ops give a done pulse each cycle.

Test Plan:
- Reset, then load A=7, B=-3, start op=ADD -> result 4 one edge later; done 1 cycle; zero=0, negative=0; alu_out puts 0x0004 on data.
- A=-7, B=2, start DIV -> busy for 17 cycles, result -3 (0xFFFD), negative=1; repeat with MOD -> result -1 (0xFFFF).
- A=300, B=300, start MUL -> after 17 cycles result 0x5F90 (24464); A=-5, B=6 MUL -> -30 (0xFFE2).
- A=5, B=0, start DIV -> result 0, div_by_zero=1, zero=1. Then ADD 1+1 -> result 2, div_by_zero=0.
- A=-32768, B=-1: DIV -> 0x8000, MOD -> 0. Pulse start and a_in=1 with data=9 mid-CALC -> ignored, result unchanged, A still -32768.
- Start DIV, assert rst at cycle 8 -> next edge busy=0, done=0, result 0, zero=1; no done pulse follows.
